instr_fetch_unit: RTL and testbench

//  Fetch stage feeding the multicycle control FSM. Holds the PC, issues word reads to instruction

---
 rtl/instr_fetch_unit.sv | 171 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, reads instruction words from memory on the
// control FSM's fetch strobe, latches the returned word into the IR and decodes its
// fields. It also applies PC redirects (JR, J/JAL, BEQ/BNE) while idle.
// Optional feature macro: IFU_TIMEOUT_EN. When defined, a fetch that waits MAX_WAIT
// cycles without mem_valid is abandoned and the sticky fetch_err flag is raised.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 16            // must be >= 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instrReg,
    input  logic        pc_wr,
    input  logic        jump,
    input  logic        jr,
    input  logic        beq,
    input  logic        bne,
    input  logic        zero,
    input  logic [31:0] rs_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid,
    output logic        instr_valid,
    output logic        busy,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  funct,
    output logic [15:0] imm,
    output logic [25:0] target,
    output logic        fetch_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        pending_q, pending_d;
    logic        instr_valid_q, instr_valid_d;

    logic [31:0] pc_inc;
    logic [31:0] branch_off;
    logic        branch_taken;
    logic [31:0] redirect_pc;

`ifdef IFU_TIMEOUT_EN
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        fetch_err_q, fetch_err_d;
`endif

    assign pc_inc       = pc_q + 32'd4;
    assign branch_off   = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
    assign branch_taken = (beq & zero) | (bne & ~zero);

    // Redirect target selection; JR wins over jump, jump over branch, else PC holds.
    always_comb begin
        redirect_pc = pc_q;
        if (jr) begin
            redirect_pc = {rs_data[31:2], 2'b00};
        end else if (jump) begin
            redirect_pc = {pc_q[31:28], ir_q[25:0], 2'b00};
        end else if (branch_taken) begin
            redirect_pc = pc_q + branch_off;
        end
    end

    // Next-state logic: redirects and fetch issue in IDLE, completion (or timeout) in WAIT.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        pending_d     = pending_q;
        instr_valid_d = 1'b0;
`ifdef IFU_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        fetch_err_d   = fetch_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pc_wr) begin
                    // A fetch requested together with a redirect is deferred one cycle
                    // so that it reads from the redirected PC.
                    pc_d      = redirect_pc;
                    pending_d = pending_q | instrReg;
                end else if (instrReg | pending_q) begin
                    state_d   = S_WAIT;
                    pending_d = 1'b0;
`ifdef IFU_TIMEOUT_EN
                    wait_cnt_d = 16'd0;
`endif
                end
            end
            S_WAIT: begin
                if (mem_valid) begin
                    ir_d          = mem_rdata;
                    pc_d          = pc_inc;
                    instr_valid_d = 1'b1;
                    state_d       = S_IDLE;
`ifdef IFU_TIMEOUT_EN
                end else if (wait_cnt_q == 16'(MAX_WAIT - 1)) begin
                    // Last allowed wait cycle elapsed: give up, leave PC and IR untouched.
                    fetch_err_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset; reset also drops any outstanding fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            ir_q          <= 32'd0;
            pending_q     <= 1'b0;
            instr_valid_q <= 1'b0;
`ifdef IFU_TIMEOUT_EN
            wait_cnt_q    <= 16'd0;
            fetch_err_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            pending_q     <= pending_d;
            instr_valid_q <= instr_valid_d;
`ifdef IFU_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
            fetch_err_q   <= fetch_err_d;
`endif
        end
    end

`ifdef IFU_TIMEOUT_EN
    assign fetch_err = fetch_err_q;
`else
    assign fetch_err = 1'b0;
`endif

    // The request is a pure function of the registered state, so it never glitches.
    assign mem_req     = (state_q == S_WAIT);
    assign busy        = (state_q == S_WAIT);
    assign mem_addr    = {pc_q[31:2], 2'b00};
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_inc;
    assign opcode      = ir_q[31:26];
    assign rs          = ir_q[25:21];
    assign rt          = ir_q[20:16];
    assign rd          = ir_q[15:11];
    assign funct       = ir_q[5:0];
    assign imm         = ir_q[15:0];
    assign target      = ir_q[25:0];

    // JR targets are word aligned, so the low rs_data bits are intentionally dropped.
    logic unused_ok;
    assign unused_ok = &{1'b0, rs_data[1:0], (MAX_WAIT > 0)};

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios followed by randomized fetches and
// redirects, all checked against a transaction-level model of PC and IR.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, instrReg, pc_wr, jump, jr, beq, bne, zero, mem_valid;
    logic [31:0] rs_data, mem_rdata, mem_addr, pc, pc_plus4;
    logic        mem_req, instr_valid, busy, fetch_err;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] target;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural PC and IR only.
    logic [31:0] model_pc;
    logic [31:0] model_ir;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .MAX_WAIT(16)) dut (
        .clk(clk), .reset(reset), .instrReg(instrReg), .pc_wr(pc_wr),
        .jump(jump), .jr(jr), .beq(beq), .bne(bne), .zero(zero),
        .rs_data(rs_data), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .instr_valid(instr_valid),
        .busy(busy), .pc(pc), .pc_plus4(pc_plus4), .opcode(opcode), .rs(rs),
        .rt(rt), .rd(rd), .funct(funct), .imm(imm), .target(target),
        .fetch_err(fetch_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, " pc"},       pc,       model_pc);
        chk({tag, " pc_plus4"}, pc_plus4, model_pc + 32'd4);
        chk({tag, " opcode"},   32'(opcode), 32'(model_ir[31:26]));
        chk({tag, " rs"},       32'(rs),     32'(model_ir[25:21]));
        chk({tag, " rt"},       32'(rt),     32'(model_ir[20:16]));
        chk({tag, " rd"},       32'(rd),     32'(model_ir[15:11]));
        chk({tag, " funct"},    32'(funct),  32'(model_ir[5:0]));
        chk({tag, " imm"},      32'(imm),    32'(model_ir[15:0]));
        chk({tag, " target"},   32'(target), 32'(model_ir[25:0]));
    endtask

    // Architectural next PC for a redirect, from the instruction-set rules.
    function automatic logic [31:0] model_redirect(input bit j, input bit r, input bit bq,
                                                   input bit bn, input bit z,
                                                   input logic [31:0] rsd);
        int off;
        if (r) return rsd & ~32'd3;
        if (j) return {model_pc[31:28], model_ir[25:0], 2'b00};
        if ((bq && z) || (bn && !z)) begin
            off = $signed(model_ir[15:0]);
            return model_pc + 32'(off * 4);
        end
        return model_pc;
    endfunction

    // One fetch: issue (unless a pending request already exists), wait lat cycles, complete.
    task automatic do_fetch(input logic [31:0] data, input int lat, input bit repulse,
                            input bit pre_issued, input string tag);
        logic [31:0] addr;
        addr = model_pc;
        if (!pre_issued) instrReg = 1'b1;
        step();
        instrReg = 1'b0;
        chk({tag, " mem_req"},  32'(mem_req), 32'd1);
        chk({tag, " mem_addr"}, mem_addr, addr);
        chk({tag, " busy"},     32'(busy), 32'd1);
        for (int i = 1; i < lat; i++) begin
            if (repulse) instrReg = 1'b1;
            step();
            instrReg = 1'b0;
            chk({tag, " addr_stable"}, mem_addr, addr);
            chk({tag, " req_held"},    32'(mem_req), 32'd1);
            chk({tag, " no_early_iv"}, 32'(instr_valid), 32'd0);
        end
        mem_valid = 1'b1;
        mem_rdata = data;
        step();
        mem_valid = 1'b0;
        mem_rdata = $urandom;
        model_ir = data;
        model_pc = addr + 32'd4;
        chk({tag, " instr_valid"}, 32'(instr_valid), 32'd1);
        chk({tag, " busy_done"},   32'(busy), 32'd0);
        chk({tag, " req_done"},    32'(mem_req), 32'd0);
        check_regs(tag);
        step();
        chk({tag, " iv_once"},  32'(instr_valid), 32'd0);
        chk({tag, " idle"},     32'(busy), 32'd0);
        $display("fetch %s: addr=%08h data=%08h lat=%0d repulse=%0d pc=%08h",
                 tag, addr, data, lat, repulse, pc);
    endtask

    task automatic do_redirect(input bit j, input bit r, input bit bq, input bit bn,
                               input bit z, input logic [31:0] rsd, input string tag);
        logic [31:0] exp_pc;
        exp_pc = model_redirect(j, r, bq, bn, z, rsd);
        pc_wr = 1'b1; jump = j; jr = r; beq = bq; bne = bn; zero = z; rs_data = rsd;
        step();
        pc_wr = 1'b0; jump = 1'b0; jr = 1'b0; beq = 1'b0; bne = 1'b0; zero = 1'b0;
        model_pc = exp_pc;
        chk({tag, " pc"},   pc, model_pc);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        $display("redirect %s: j=%0d jr=%0d beq=%0d bne=%0d zero=%0d rs=%08h pc=%08h",
                 tag, j, r, bq, bn, z, rsd, pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; instrReg = 1'b0; pc_wr = 1'b0; jump = 1'b0; jr = 1'b0;
        beq = 1'b0; bne = 1'b0; zero = 1'b0; rs_data = 32'd0;
        mem_rdata = 32'd0; mem_valid = 1'b0;
        model_pc = RESET_PC;
        model_ir = 32'd0;
        step();
        step();
        reset = 1'b0;
        chk("reset mem_req",     32'(mem_req), 32'd0);
        chk("reset instr_valid", 32'(instr_valid), 32'd0);
        chk("reset busy",        32'(busy), 32'd0);
        chk("reset fetch_err",   32'(fetch_err), 32'd0);
        check_regs("reset");
        $display("reset: pc=%08h ir fields cleared", pc);

        // Basic fetch with minimum latency, then a BEQ instruction.
        do_fetch(32'h0000_002A, 1, 1'b0, 1'b0, "first");
        do_fetch(32'h1000_0003, 2, 1'b0, 1'b0, "beq_word");
        do_redirect(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, "beq_not_taken");
        chk("beq_not_taken value", pc, 32'd8);
        do_redirect(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0, "beq_taken");
        chk("beq_taken value", pc, 32'd20);

        // JAL from the 0x4xxx_xxxx region, then JR dropping low bits.
        do_redirect(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h4000_0000, "jr_hi");
        do_fetch(32'h0C00_0010, 1, 1'b0, 1'b0, "jal_word");
        do_redirect(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, "jal");
        chk("jal value", pc, 32'h4000_0040);
        do_redirect(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0103, "jr_unaligned");
        chk("jr_unaligned value", pc, 32'h0000_0100);

        // Slow memory with instrReg re-pulsed while waiting.
        do_fetch(32'h8C22_0004, 6, 1'b1, 1'b0, "slow_repulse");

        // Redirect and fetch in the same cycle: fetch must use the new PC.
        pc_wr = 1'b1; jr = 1'b1; rs_data = 32'h0000_0200; instrReg = 1'b1;
        step();
        pc_wr = 1'b0; jr = 1'b0; instrReg = 1'b0;
        model_pc = 32'h0000_0200;
        chk("redir_fetch pc",      pc, 32'h0000_0200);
        chk("redir_fetch no_req",  32'(mem_req), 32'd0);
        do_fetch(32'h2108_FFFF, 1, 1'b0, 1'b1, "redir_fetch");

        // Reset while waiting; the late mem_valid must be ignored.
        instrReg = 1'b1;
        step();
        instrReg = 1'b0;
        chk("rst_wait busy", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        mem_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_valid = 1'b0;
        model_pc = RESET_PC;
        model_ir = 32'd0;
        chk("rst_wait instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_wait busy_after",  32'(busy), 32'd0);
        chk("rst_wait mem_req",     32'(mem_req), 32'd0);
        check_regs("rst_wait");
        step();
        chk("rst_wait iv_late", 32'(instr_valid), 32'd0);
        $display("reset_in_wait: pc=%08h instr_valid=%0d", pc, instr_valid);

        // mem_valid while idle is ignored.
        mem_valid = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        mem_valid = 1'b0;
        chk("idle_valid instr_valid", 32'(instr_valid), 32'd0);
        chk("idle_valid busy",        32'(busy), 32'd0);
        check_regs("idle_valid");
        $display("idle_mem_valid: ignored, pc=%08h", pc);

        // Memory that stalls for longer than MAX_WAIT cycles.
        instrReg = 1'b1;
        step();
        instrReg = 1'b0;
`ifdef IFU_TIMEOUT_EN
        for (int i = 1; i < 16; i++) step();
        chk("timeout still_busy", 32'(busy), 32'd1);
        chk("timeout err_early",  32'(fetch_err), 32'd0);
        step();
        chk("timeout fetch_err",  32'(fetch_err), 32'd1);
        chk("timeout mem_req",    32'(mem_req), 32'd0);
        chk("timeout busy",       32'(busy), 32'd0);
        check_regs("timeout");
        step();
        chk("timeout sticky",     32'(fetch_err), 32'd1);
        $display("timeout: fetch_err=%0d busy=%0d", fetch_err, busy);
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_pc = RESET_PC;
        model_ir = 32'd0;
        chk("timeout cleared", 32'(fetch_err), 32'd0);
`else
        for (int i = 0; i < 20; i++) step();
        chk("long_wait busy",      32'(busy), 32'd1);
        chk("long_wait mem_req",   32'(mem_req), 32'd1);
        chk("long_wait fetch_err", 32'(fetch_err), 32'd0);
        mem_valid = 1'b1; mem_rdata = 32'hAC01_0008;
        step();
        mem_valid = 1'b0;
        model_ir = 32'hAC01_0008;
        model_pc = model_pc + 32'd4;
        chk("long_wait instr_valid", 32'(instr_valid), 32'd1);
        check_regs("long_wait");
        step();
        $display("long_wait: completed after 21 cycles, pc=%08h", pc);
`endif

        // Randomized mix of fetches and redirects.
        for (int n = 0; n < 40; n++) begin
            int op;
            op = $urandom_range(0, 2);
            if (op < 2) begin
                do_fetch($urandom, $urandom_range(1, 4), 1'($urandom_range(0, 1)), 1'b0, "rand");
            end else begin
                do_redirect(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)), $urandom, "rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
